// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-side hazard unit with a per-register pending-result scoreboard.
//   Each GPR carries a countdown of cycles until its in-flight result can be
//   forwarded. Readers of a register whose countdown is nonzero are stalled.
//   A single MDU is tracked by its own occupancy countdown.
//   Forward selects for the two sources come from the E/M/W destinations,
//   with the youngest producer taking priority.
//
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   validD                  decode holds a real instruction
//   rsD/rtD, rs_useD/rt_useD  source indices and read enables
//   dstD, wrD, kindD        destination, write enable, producer kind
//                           (0 ALU, 1 LOAD, 2 MDU, 3 treated as ALU)
//   dstE/wrE, dstM/wrM, dstW/wrW  destinations of E/M/W instructions
//   exc_flush               squash all younger in-flight work
//   stallF, stallD, flushE  pipeline controls
//   forwardA, forwardB      source selects: 0 RF, 1 E, 2 M, 3 W
//   mdu_busy                MDU occupied
//   raw_stall_cnt, struct_stall_cnt  stall-cause counters, present only
//                           when HAZARD_PERF_EN is defined
module hazard_scoreboard #(
  parameter int REG_NUM  = 32,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             validD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             rs_useD,
  input  logic             rt_useD,
  input  logic [REG_W-1:0] dstD,
  input  logic             wrD,
  input  logic [1:0]       kindD,
  input  logic [REG_W-1:0] dstE,
  input  logic             wrE,
  input  logic [REG_W-1:0] dstM,
  input  logic             wrM,
  input  logic [REG_W-1:0] dstW,
  input  logic             wrW,
  input  logic             exc_flush,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      raw_stall_cnt,
  output logic [31:0]      struct_stall_cnt,
`endif
  output logic             mdu_busy
);

  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_MDU  = 2'd2;

  logic [CNT_W-1:0] pend_q [REG_NUM];
  logic [CNT_W-1:0] pend_d [REG_NUM];
  logic [CNT_W-1:0] mdu_q, mdu_d;
  logic [CNT_W-1:0] lat_s;
  logic             raw_s, struct_s, stall_s, issue_s;

  // Youngest-first forward select for one source operand.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src, input logic use_src,
    input logic [REG_W-1:0] de, input logic we,
    input logic [REG_W-1:0] dm, input logic wm,
    input logic [REG_W-1:0] dw, input logic ww);
    logic [1:0] sel;
    if (!use_src || src == '0) begin
      sel = 2'd0;
    end else if (we && de == src) begin
      sel = 2'd1;
    end else if (wm && dm == src) begin
      sel = 2'd2;
    end else if (ww && dw == src) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Hazard detection and stall/flush controls.
  always_comb begin
    raw_s    = (rs_useD && rsD != '0 && pend_q[rsD] != '0) ||
               (rt_useD && rtD != '0 && pend_q[rtD] != '0);
    struct_s = (kindD == KIND_MDU) && wrD && (mdu_q != '0);
    stall_s  = validD && (raw_s || struct_s) && !exc_flush;
    issue_s  = validD && !stall_s && !exc_flush;
  end

  // Result latency of the instruction in decode.
  always_comb begin
    case (kindD)
      KIND_LOAD: lat_s = CNT_W'(LOAD_LAT);
      KIND_MDU:  lat_s = CNT_W'(MDU_LAT);
      default:   lat_s = '0;
    endcase
  end

  // Scoreboard next state: flush clears, issue overrides, otherwise count down.
  always_comb begin
    pend_d[0] = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      if (exc_flush) begin
        pend_d[r] = '0;
      end else if (issue_s && wrD && dstD == REG_W'(r)) begin
        pend_d[r] = lat_s;
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - CNT_W'(1);
      end else begin
        pend_d[r] = '0;
      end
    end
    if (exc_flush) begin
      mdu_d = '0;
    end else if (issue_s && kindD == KIND_MDU) begin
      mdu_d = CNT_W'(MDU_LAT);
    end else if (mdu_q != '0) begin
      mdu_d = mdu_q - CNT_W'(1);
    end else begin
      mdu_d = '0;
    end
  end

  // Scoreboard and MDU occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < REG_NUM; r++) pend_q[r] <= '0;
      mdu_q <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) pend_q[r] <= pend_d[r];
      mdu_q <= mdu_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] raw_cnt_q, struct_cnt_q;

  // Stall-cause counters; a raw hazard takes credit when both causes coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_cnt_q    <= 32'd0;
      struct_cnt_q <= 32'd0;
    end else begin
      if (stall_s && raw_s)  raw_cnt_q    <= raw_cnt_q + 32'd1;
      if (stall_s && !raw_s) struct_cnt_q <= struct_cnt_q + 32'd1;
    end
  end

  assign raw_stall_cnt    = raw_cnt_q;
  assign struct_stall_cnt = struct_cnt_q;
`endif

  assign stallD   = stall_s;
  assign stallF   = stall_s;
  assign flushE   = stall_s || exc_flush;
  assign mdu_busy = (mdu_q != '0);
  assign forwardA = fwd_sel(rsD, rs_useD, dstE, wrE, dstM, wrM, dstW, wrW);
  assign forwardB = fwd_sel(rtD, rt_useD, dstE, wrE, dstM, wrM, dstW, wrW);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       validD, rs_useD, rt_useD, wrD, wrE, wrM, wrW, exc_flush;
  logic [4:0] rsD, rtD, dstD, dstE, dstM, dstW;
  logic [1:0] kindD;
  logic       stallF, stallD, flushE, mdu_busy;
  logic [1:0] forwardA, forwardB;
`ifdef HAZARD_PERF_EN
  logic [31:0] raw_stall_cnt, struct_stall_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .resetn(resetn), .validD(validD),
    .rsD(rsD), .rtD(rtD), .rs_useD(rs_useD), .rt_useD(rt_useD),
    .dstD(dstD), .wrD(wrD), .kindD(kindD),
    .dstE(dstE), .wrE(wrE), .dstM(dstM), .wrM(wrM), .dstW(dstW), .wrW(wrW),
    .exc_flush(exc_flush), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardA(forwardA), .forwardB(forwardB),
`ifdef HAZARD_PERF_EN
    .raw_stall_cnt(raw_stall_cnt), .struct_stall_cnt(struct_stall_cnt),
`endif
    .mdu_busy(mdu_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode-stage instruction.
  task automatic set_d(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic [4:0] dst, input logic wr, input logic [1:0] kind);
    validD = v; rsD = rs; rs_useD = rsu; rtD = rt; rt_useD = rtu;
    dstD = dst; wrD = wr; kindD = kind;
  endtask

  // E/M/W destinations.
  task automatic set_emw(input logic we, input logic [4:0] de, input logic wm,
                         input logic [4:0] dm, input logic ww, input logic [4:0] dw);
    wrE = we; dstE = de; wrM = wm; dstM = dm; wrW = ww; dstW = dw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0; exc_flush = 1'b0;
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    set_emw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    check("rst_stallD", {31'd0, stallD}, 32'd0);
    check("rst_flushE", {31'd0, flushE}, 32'd0);
    check("rst_mdu_busy", {31'd0, mdu_busy}, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Load-use: LOAD r5, then ADD r6 <- r5.
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
    settle();
    check("ld_issue_stall", {31'd0, stallD}, 32'd0);
    step();
    set_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0);
    set_emw(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    check("lu_stallD", {31'd0, stallD}, 32'd1);
    check("lu_stallF", {31'd0, stallF}, 32'd1);
    check("lu_flushE", {31'd0, flushE}, 32'd1);
    step();
    set_emw(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    settle();
    check("lu_release", {31'd0, stallD}, 32'd0);
    check("lu_fwdA_M", {30'd0, forwardA}, 32'd2);
    step();

    // ALU back-to-back: ADD r3, then SUB r4 <- r3, r0.
    set_emw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd0);
    step();
    set_d(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 2'd0);
    set_emw(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    check("alu_stall", {31'd0, stallD}, 32'd0);
    check("alu_fwdA_E", {30'd0, forwardA}, 32'd1);
    check("alu_fwdB_r0", {30'd0, forwardB}, 32'd0);
    step();
    set_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'd1);
    set_emw(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    settle();
    check("r0_fwdA", {30'd0, forwardA}, 32'd0);
    step();
    set_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    settle();
    check("r0_never_stall", {31'd0, stallD}, 32'd0);
    set_emw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();

    // MDU: MUL r8, dependent reader stalls 4 cycles.
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
    settle();
    check("mul_issue_stall", {31'd0, stallD}, 32'd0);
    step();
    set_d(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("mdu_dep_stall%0d", i), {31'd0, stallD}, 32'd1);
      check($sformatf("mdu_busy%0d", i), {31'd0, mdu_busy}, 32'd1);
      step();
    end
    check("mdu_dep_release", {31'd0, stallD}, 32'd0);
    check("mdu_idle", {31'd0, mdu_busy}, 32'd0);
    step();

    // Structural: MUL r8, idle one cycle, then MUL r10 waits for the MDU.
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
    step();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    step();
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("struct_stall%0d", i), {31'd0, stallD}, 32'd1);
      step();
    end
    check("struct_release", {31'd0, stallD}, 32'd0);
    step();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step();
    check("mdu_drained", {31'd0, mdu_busy}, 32'd0);

    // Forwarding priority on r7.
    set_emw(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7);
    set_d(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0);
    settle();
    check("prio_fwdA", {30'd0, forwardA}, 32'd1);
    check("prio_fwdB", {30'd0, forwardB}, 32'd1);
    wrE = 1'b0;
    settle();
    check("prio_fwdA_M", {30'd0, forwardA}, 32'd2);
    wrM = 1'b0;
    settle();
    check("prio_fwdA_W", {30'd0, forwardA}, 32'd3);
    rt_useD = 1'b0;
    settle();
    check("unused_fwdB", {30'd0, forwardB}, 32'd0);
    set_emw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();

    // Flush mid-MDU; LOAD r12 presented during the flush is not recorded.
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
    step();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    step();
    set_d(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'd1);
    exc_flush = 1'b1;
    settle();
    check("fl_flushE", {31'd0, flushE}, 32'd1);
    check("fl_stallD", {31'd0, stallD}, 32'd0);
    check("fl_busy_before", {31'd0, mdu_busy}, 32'd1);
    step();
    exc_flush = 1'b0;
    set_d(1'b1, 5'd8, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 2'd0);
    settle();
    check("fl_mdu_busy", {31'd0, mdu_busy}, 32'd0);
    check("fl_reader_stall", {31'd0, stallD}, 32'd0);
    check("fl_flushE_off", {31'd0, flushE}, 32'd0);
    step();

    // Reset mid-operation while r9 has 3 cycles left.
    set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
    step();
    set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    step();
    set_d(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'd0);
    settle();
    check("rm_stall_before", {31'd0, stallD}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rm_stall_async", {31'd0, stallD}, 32'd0);
    check("rm_busy_async", {31'd0, mdu_busy}, 32'd0);
    #1;
    resetn = 1'b1;
    step();
    set_d(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    settle();
    check("rm_stall_after", {31'd0, stallD}, 32'd0);
    check("rm_busy_after", {31'd0, mdu_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
